// File: rtl/fifo_rd_stream.sv
// Read-side master for the synchronous FIFO: issues reads against a credit budget, absorbs the
// fixed read latency, and re-presents the words as a valid/ready stream through a skid buffer.

module fifo_rd_stream #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_en,
  input  logic              i_flush,
  output logic              o_rden,
  input  logic              i_empty,
  input  logic              i_alm_empty,
  input  logic [DATA_W-1:0] i_rddata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_busy,
  output logic [31:0]       o_rd_cnt,
  output logic              o_low_water
);

  localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;

  if (RD_LAT < 1 || RD_LAT > 3) begin : gen_bad_rd_lat
    $error("fifo_rd_stream: RD_LAT must be in 1..3");
  end
  if (SKID_DEPTH < RD_LAT + 1) begin : gen_bad_skid_depth
    $error("fifo_rd_stream: SKID_DEPTH must be at least RD_LAT+1");
  end

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   occ_q;
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic [31:0]       rd_cnt_q;
  logic              low_water_q;

  logic              pop;
  logic              push;
  logic              rden;
  logic [CntW-1:0]   infl_cnt;
  logic [CntW-1:0]   credit_use;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl_cnt = infl_cnt + CntW'(infl_q[i]);
    end
  end

  // Credit counts both stored words and reads still in flight, so every returning word has room.
  assign pop        = (occ_q != '0) & i_ready;
  assign push       = infl_q[RD_LAT-1] & ~i_flush;
  assign credit_use = occ_q - CntW'(pop) + infl_cnt;
  assign rden       = i_en & ~i_empty & ~i_flush & (credit_use < CntW'(SKID_DEPTH));

  always_comb begin
    infl_d    = '0;
    infl_d[0] = rden;
    for (int i = 1; i < RD_LAT; i++) begin
      infl_d[i] = infl_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      infl_q      <= '0;
      rd_cnt_q    <= '0;
      low_water_q <= 1'b0;
    end else begin
      low_water_q <= i_alm_empty;
      if (pop) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (i_flush) begin
        // Returning data from pre-flush reads is dropped by clearing the in-flight bits.
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
        infl_q   <= '0;
      end else begin
        infl_q <= infl_d;
        if (push) begin
          mem_q[wr_ptr_q] <= i_rddata;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (pop) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
        occ_q <= occ_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  // Gate with rstn so no read can leak out while reset is held.
  assign o_rden      = rden & rstn;
  assign o_valid     = (occ_q != '0);
  assign o_data      = mem_q[rd_ptr_q];
  assign o_busy      = (occ_q != '0) | (|infl_q);
  assign o_rd_cnt    = rd_cnt_q;
  assign o_low_water = low_water_q;

  a_no_rden_when_empty: assert property (@(posedge clk) disable iff (!rstn)
    o_rden |-> !i_empty);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    (occ_q + infl_cnt) <= CntW'(SKID_DEPTH));

  a_hold_while_stalled: assert property (@(posedge clk) disable iff (!rstn)
    (o_valid && !i_ready && !i_flush) |=> (o_valid && $stable(o_data)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural RD_LAT=1 FIFO and a cycle-level stream model.

module tb_fifo_rd_stream;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_en = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_rden, i_empty, i_alm_empty, o_valid, o_busy, o_low_water;
  logic [DW-1:0] i_rddata = '0;
  logic [DW-1:0] o_data;
  logic [31:0]   o_rd_cnt;

  fifo_rd_stream #(.DATA_W(DW), .RD_LAT(1), .SKID_DEPTH(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_en        (i_en),
    .i_flush     (i_flush),
    .o_rden      (o_rden),
    .i_empty     (i_empty),
    .i_alm_empty (i_alm_empty),
    .i_rddata    (i_rddata),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_rd_cnt    (o_rd_cnt),
    .o_low_water (o_low_water)
  );

  always #5 clk = ~clk;

  // FIFO with one cycle of read latency.
  logic [DW-1:0] fmem [256];
  int unsigned   fwr = 0;
  int unsigned   frd = 0;
  assign i_empty     = (fwr == frd);
  assign i_alm_empty = ((fwr - frd) <= 1);
  always @(posedge clk) begin
    if (o_rden) begin
      i_rddata <= fmem[frd[7:0]];
      frd      <= frd + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  // Stream model state: words stored and reads in flight as seen before the next edge.
  int            occ_m = 0;
  int            inf_m = 0;
  int            cyc_n = 0;
  int            ngot, nrden, nvalid, first_rden, last_rden, first_valid;
  logic [DW-1:0] got [64];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [3:0]    pat = 4'b1001;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    i_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      fmem[fwr[7:0]] = base + DW'(k);
      fwr++;
    end
  endtask

  task automatic start_test();
    ngot        = 0;
    nrden       = 0;
    nvalid      = 0;
    first_rden  = -1;
    last_rden   = -1;
    first_valid = -1;
  endtask

  task automatic cyc(input logic rdy, input logic en, input logic fl);
    int   pop;
    logic exp_rden;
    @(negedge clk);
    i_ready = rdy;
    i_en    = en;
    i_flush = fl;
    #1;
    pop      = (occ_m != 0 && rdy) ? 1 : 0;
    exp_rden = en && !i_empty && !fl && (occ_m + inf_m - pop < 2);
    chk("valid", DW'(o_valid), DW'(occ_m != 0));
    chk("busy", DW'(o_busy), DW'(occ_m != 0 || inf_m != 0));
    chk("rden", DW'(o_rden), DW'(exp_rden));
    if (prev_stall) begin
      chk("hold_valid", DW'(o_valid), DW'(1));
      chk("hold_data", o_data, prev_data);
    end
    prev_stall = o_valid && !rdy && !fl;
    prev_data  = o_data;
    if (o_valid && rdy && ngot < 64) begin
      got[ngot] = o_data;
      ngot++;
    end
    if (o_rden) begin
      nrden++;
      if (first_rden < 0) first_rden = cyc_n;
      last_rden = cyc_n;
    end
    if (o_valid) begin
      nvalid++;
      if (first_valid < 0) first_valid = cyc_n;
    end
    occ_m = fl ? 0 : occ_m + inf_m - pop;
    inf_m = fl ? 0 : int'(exp_rden);
    cyc_n++;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", DW'(o_valid), DW'(0));
    chk("rst_data", o_data, DW'(0));
    chk("rst_busy", DW'(o_busy), DW'(0));
    chk("rst_cnt", DW'(o_rd_cnt), DW'(0));
    chk("rst_low_water", DW'(o_low_water), DW'(0));
    chk("rst_rden", DW'(o_rden), DW'(0));
    @(negedge clk);
    rstn = 1'b1;

    // Full-rate burst of 8 words
    load(8, DW'('h1));
    start_test();
    repeat (14) cyc(1'b1, 1'b1, 1'b0);
    chk("t1_ngot", DW'(ngot), DW'(8));
    for (int k = 0; k < 8; k++) chk("t1_word", got[k], DW'(k + 1));
    chk("t1_nrden", DW'(nrden), DW'(8));
    chk("t1_rden_span", DW'(last_rden - first_rden), DW'(7));
    chk("t1_latency", DW'(first_valid - first_rden), DW'(2));
    chk("t1_cnt", DW'(o_rd_cnt), DW'(8));
    chk("t1_busy", DW'(o_busy), DW'(0));
    chk("t1_low_water", DW'(o_low_water), DW'(1));

    // Ready toggling 1,0,0,1
    load(8, DW'('h11));
    start_test();
    for (int i = 0; i < 32; i++) cyc(pat[i % 4], 1'b1, 1'b0);
    chk("t2_ngot", DW'(ngot), DW'(8));
    for (int k = 0; k < 8; k++) chk("t2_word", got[k], DW'('h11 + k));
    chk("t2_cnt", DW'(o_rd_cnt), DW'(16));
    chk("t2_busy", DW'(o_busy), DW'(0));

    // Single word
    load(1, DW'('h21));
    start_test();
    repeat (6) cyc(1'b1, 1'b1, 1'b0);
    chk("t3_nrden", DW'(nrden), DW'(1));
    chk("t3_nvalid", DW'(nvalid), DW'(1));
    chk("t3_word", got[0], DW'('h21));
    chk("t3_cnt", DW'(o_rd_cnt), DW'(17));

    // Fill under back-pressure, then flush
    load(6, DW'('h31));
    start_test();
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("t4_full_valid", DW'(o_valid), DW'(1));
    chk("t4_full_rden", DW'(o_rden), DW'(0));
    chk("t4_full_data", o_data, DW'('h31));
    chk("t4_nrden", DW'(nrden), DW'(2));
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4_valid_after_flush", DW'(o_valid), DW'(0));
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    chk("t4_ngot", DW'(ngot), DW'(4));
    for (int k = 0; k < 4; k++) chk("t4_word", got[k], DW'('h33 + k));
    chk("t4_cnt", DW'(o_rd_cnt), DW'(21));

    // Asynchronous reset mid-burst
    load(8, DW'('h41));
    start_test();
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    chk("t5_pre_ngot", DW'(ngot), DW'(2));
    chk("t5_pre_word0", got[0], DW'('h41));
    chk("t5_pre_word1", got[1], DW'('h42));
    @(negedge clk);
    #1;
    chk("t5_pre_valid", DW'(o_valid), DW'(1));
    rstn = 1'b0;
    i_en = 1'b0;
    #1;
    chk("t5_rst_valid", DW'(o_valid), DW'(0));
    chk("t5_rst_rden", DW'(o_rden), DW'(0));
    chk("t5_rst_busy", DW'(o_busy), DW'(0));
    chk("t5_rst_cnt", DW'(o_rd_cnt), DW'(0));
    @(negedge clk);
    rstn       = 1'b1;
    occ_m      = 0;
    inf_m      = 0;
    prev_stall = 1'b0;
    start_test();
    repeat (12) cyc(1'b1, 1'b1, 1'b0);
    chk("t5_ngot", DW'(ngot), DW'(4));
    for (int k = 0; k < 4; k++) chk("t5_word", got[k], DW'('h45 + k));
    chk("t5_cnt", DW'(o_rd_cnt), DW'(4));

    // Enable dropped after three issues
    load(8, DW'('h51));
    start_test();
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    chk("t6_nrden", DW'(nrden), DW'(3));
    chk("t6_ngot", DW'(ngot), DW'(3));
    for (int k = 0; k < 3; k++) chk("t6_word", got[k], DW'('h51 + k));
    chk("t6_busy", DW'(o_busy), DW'(0));
    chk("t6_rden_off", DW'(o_rden), DW'(0));
    chk("t6_cnt", DW'(o_rd_cnt), DW'(7));
    start_test();
    repeat (12) cyc(1'b1, 1'b1, 1'b0);
    chk("t6_rest_ngot", DW'(ngot), DW'(5));
    for (int k = 0; k < 5; k++) chk("t6_rest_word", got[k], DW'('h54 + k));
    chk("t6_rest_cnt", DW'(o_rd_cnt), DW'(12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
